mem_port_arbiter: RTL

Shares the core's single memory port between the instruction-fetch requester and the data (mem stage) requester. It handles one outstanding transaction at a time and routes each response back to its owner. Data requests have priority, and a streak counter guarantees fetch progress. A flush input discards in-flight fetch responses after a redirect.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data requesters.
// One transaction in flight; data has priority, bounded by a streak counter.
module mem_port_arbiter #(
  parameter int addr_width      = 32,
  parameter int data_width      = 32,
  parameter int max_data_streak = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [addr_width-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [data_width-1:0]   if_rdata,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [addr_width-1:0]   mem_addr,
  input  logic [data_width-1:0]   mem_wdata,
  input  logic [data_width/8-1:0] mem_wstrb,
  output logic                    mem_gnt,
  output logic                    mem_rvalid,
  output logic [data_width-1:0]   mem_rdata,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [addr_width-1:0]   bus_addr,
  output logic [data_width-1:0]   bus_wdata,
  output logic [data_width/8-1:0] bus_wstrb,
  input  logic                    bus_ack,
  input  logic                    bus_rvalid,
  input  logic [data_width-1:0]   bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int SW = (max_data_streak < 1) ? 1 : $clog2(max_data_streak + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(max_data_streak);

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef struct packed {
    logic                    we;
    logic [addr_width-1:0]   addr;
    logic [data_width-1:0]   wdata;
    logic [data_width/8-1:0] wstrb;
  } bus_pay_t;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  kill_q, kill_d;
  logic                  breq_q, breq_d;
  bus_pay_t              pay_q, pay_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic [data_width-1:0] if_rdata_q, if_rdata_d;
  logic                  mem_rvalid_q, mem_rvalid_d;
  logic [data_width-1:0] mem_rdata_q, mem_rdata_d;

  logic idle, done;

  assign idle    = (state_q == S_IDLE);
  assign mem_gnt = !rst && idle && mem_req && (!if_req || (streak_q < STREAK_MAX));
  assign if_gnt  = !rst && idle && !mem_gnt && if_req && !flush;
  assign done    = ((state_q == S_REQ) && bus_ack && bus_rvalid) ||
                   ((state_q == S_WAIT) && bus_rvalid);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    kill_d       = kill_q | flush;
    breq_d       = breq_q;
    pay_d        = pay_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_gnt) begin
          pay_d    = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
          owner_d  = OWN_DATA;
          kill_d   = flush;
          breq_d   = 1'b1;
          state_d  = S_REQ;
          if (!if_req)                     streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
        end else if (if_gnt) begin
          pay_d    = '{we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0};
          owner_d  = OWN_FETCH;
          kill_d   = 1'b0;
          breq_d   = 1'b1;
          state_d  = S_REQ;
          streak_d = '0;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          breq_d  = 1'b0;
          state_d = bus_rvalid ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        breq_d  = 1'b0;
      end
    endcase

    // A flush coinciding with completion still kills the fetch response.
    if (done) begin
      if (owner_q == OWN_DATA) begin
        mem_rvalid_d = 1'b1;
        mem_rdata_d  = bus_rdata;
      end else if (!(kill_q || flush)) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      streak_q     <= '0;
      kill_q       <= 1'b0;
      breq_q       <= 1'b0;
      pay_q        <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      kill_q       <= kill_d;
      breq_q       <= breq_d;
      pay_q        <= pay_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign bus_req    = breq_q;
  assign bus_we     = pay_q.we;
  assign bus_addr   = pay_q.addr;
  assign bus_wdata  = pay_q.wdata;
  assign bus_wstrb  = pay_q.wstrb;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rvalid = mem_rvalid_q;
  assign mem_rdata  = mem_rdata_q;

endmodule
